fpu_sched: RTL and testbench
============================

# fpu_sched

Issue scheduler and result collector for the shared FPU datapath (add/sub, multiply and divide pipelines behind one `op_mode`/`a`/`b` port with a combinational, `op_mode`-selected result mux). It does the following:
- Accepts tagged operation requests over a valid/ready handshake.
- Issues at most one op per cycle to the FPU.
- Tracks in-flight ops with a completion-slot scoreboard.
- Captures each result on its exact completion cycle into a small response FIFO, returned in completion order.

## Interface
Parameters:
- `LAT_AS`, 3: add/sub issue-to-result latency (cycles)
- `LAT_MUL`, 3: multiply latency
- `LAT_DIV`, 8: divide latency; must be the largest latency
- `TAG_W`, 4: request tag width
- `BUF_DEPTH`, 4: response FIFO depth (power of two)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted this cycle when high with `req_valid`
- `req_op` in 2: 00 add, 01 sub, 10 mul, 11 div
- `req_a`, `req_b` in 32: operands (`a` = dividend for div)
- `req_tag` in TAG_W: returned with the result
- `fpu_op_mode` out 2: drives the FPU `op_mode`
- `fpu_a`, `fpu_b` out 32: drive the FPU operands
- `fpu_result`, `fpu_result2` in 32: FPU outputs
- `rsp_valid` out 1: response FIFO non-empty
- `rsp_ready` in 1: consumer accepts head
- `rsp_tag` out TAG_W, `rsp_result` out 32, `rsp_result2` out 32: FIFO head; `rsp_result2` is meaningful only for div and is 0 otherwise
- `busy` out 1: any op in flight or FIFO non-empty

## Operation
- Op class: AS = {00, 01} with latency `LAT_AS`; MUL = 10 with `LAT_MUL`; DIV = 11 with `LAT_DIV`.
- Scoreboard: shift register of `LAT_DIV` slots, each holding {valid, op, tag}. Every cycle it shifts by one toward slot 1. On issue, the request is written into slot L (its latency). Slot 1 valid means the op completes this cycle.
- Issue: combinational, same cycle as acceptance. `req_ready` is high only when all three conditions hold:
  - (a) target slot L is free after the shift.
  - (b) no completion is present this cycle, or the completing op's class equals the request's class. The FPU result mux follows the current `op_mode`, so a mismatch would select the wrong unit.
  - (c) in-flight count + FIFO occupancy < `BUF_DEPTH`. This credit rule guarantees FIFO space for every completion.
- `fpu_op_mode` selection:
  - Issue cycle: the issuing op.
  - Else, completion cycle: the completing op.
  - Else: holds its previous value.
- `fpu_a`/`fpu_b` carry `req_a`/`req_b` on the issue cycle and hold their last values otherwise.
- Capture: when slot 1 is valid, push {tag, `fpu_result`, DIV ? `fpu_result2` : 0} into the FIFO at the clock edge.
- FIFO: circular, write and read pointers one bit wider than the index. Push and pop in the same cycle leave occupancy unchanged. No push is ever dropped, by the credit rule.
- Responses leave in completion order, not issue order (e.g. a mul issued after a div returns first).

## Timing
- An op issued in cycle t has its FPU result valid combinationally in cycle t+L and captured at the end of t+L. `rsp_valid` can rise in cycle t+L+1 at the earliest.
- Reset values (`reset`==0 at the edge):
  - Scoreboard all invalid, FIFO empty.
  - `rsp_valid`=0, `rsp_tag`/`rsp_result`/`rsp_result2`=0.
  - `fpu_op_mode`=00, `fpu_a`/`fpu_b`=0, `busy`=0.
  - `req_ready`=0 while reset is asserted.
- Reset mid-operation: all in-flight ops are discarded. FPU outputs emerging afterwards are ignored because no slot is valid.
- Throughput: one op per cycle when consecutive ops share a class and FIFO credits are available.
- Same-latency ops in different classes (AS and MUL, both 3) never collide: each gets a distinct slot by rule (a).

## Configuration
- `FPU_SCHED_PERF_EN` defined: adds outputs `perf_issued` (32) and `perf_stalls` (32).
  - `perf_issued` counts accepted requests.
  - `perf_stalls` counts cycles with `req_valid`=1 and `req_ready`=0.
  - Both wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent and all other behaviour is identical.

## Test plan
- Add back-to-back: tags 1,2,3 with a=1.0 (0x3F800000), b=2.0 (0x40000000), issued cycles 0–2 -> `req_ready` held high, responses tag 1,2,3 with result 0x40400000, first capture at the end of cycle 3.
- Class conflict: div (a=6.0, b=2.0, tag 5) at cycle 0, then an add requested at cycle 8 -> add stalled in cycle 8 (div completes), issued in cycle 9; div response 0x40400000 precedes the add response.
- Reorder: div tag 1 at cycle 0, mul tag 2 (3.0×2.0) at cycle 1 -> responses tag 2 (0x40C00000), then tag 1.
- Backpressure: `rsp_ready`=0 and 6 add requests -> exactly 4 accepted, then `req_ready`=0. Raising `rsp_ready` drains tags in order and resumes issue; no result lost.
- Reset mid-flight: issue div, drop `reset` to 0 for one cycle at cycle 3 -> `rsp_valid` stays 0 through cycle 12 and `busy`=0 from cycle 4.
- `FPU_SCHED_PERF_EN`: the backpressure test yields `perf_issued`=4 and `perf_stalls` equal to the stalled-cycle count.

Source files
------------

// File: rtl/fpu_sched.sv
// fpu_sched: issue scheduler and in-order-of-completion result collector for the shared FPU.
// Optional perf counters under `FPU_SCHED_PERF_EN`.
module fpu_sched #(
   parameter int LAT_AS    = 3,
   parameter int LAT_MUL   = 3,
   parameter int LAT_DIV   = 8,
   parameter int TAG_W     = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [1:0]       fpu_op_mode,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   input  logic [31:0]      fpu_result,
   input  logic [31:0]      fpu_result2,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [31:0]      rsp_result,
   output logic [31:0]      rsp_result2,
   output logic             busy
`ifdef FPU_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stalls
`endif
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = 8;

   logic [LAT_DIV:1] sb_v, sh_v, tgt;
   logic [1:0]       sb_op  [LAT_DIV:1];
   logic [TAG_W-1:0] sb_tag [LAT_DIV:1];

   logic [TAG_W-1:0] f_tag [BUF_DEPTH];
   logic [31:0]      f_r   [BUF_DEPTH];
   logic [31:0]      f_r2  [BUF_DEPTH];
   logic [AW:0]      wptr, rptr, occ;

   logic [CW-1:0] n_fly;
   logic          slot_ok, cls_ok, credit_ok;
   logic          issue, push, pop;
   logic [1:0]    mode_q;
   logic [31:0]   a_q, b_q;
   int            l_req;

   function automatic logic [1:0] op_cls(input logic [1:0] op);
      unique case (1'b1)
         op == 2'b11: op_cls = 2'd2;
         op == 2'b10: op_cls = 2'd1;
         default:     op_cls = 2'd0;
      endcase
   endfunction

   function automatic int op_lat(input logic [1:0] op);
      unique case (1'b1)
         op == 2'b11: op_lat = LAT_DIV;
         op == 2'b10: op_lat = LAT_MUL;
         default:     op_lat = LAT_AS;
      endcase
   endfunction

   always_comb begin
      sh_v  = sb_v >> 1;
      l_req = op_lat(req_op);
      tgt   = '0;
      for (int i = 1; i <= LAT_DIV; i++)
         tgt[i] = (i == l_req);
      n_fly = '0;
      for (int i = 1; i <= LAT_DIV; i++)
         n_fly = n_fly + CW'(sb_v[i]);
   end

   assign occ = wptr - rptr;

   // the result mux follows op_mode, so a completing op pins the class
   assign slot_ok   = (tgt & sh_v) == '0;
   assign cls_ok    = !sb_v[1] || (op_cls(sb_op[1]) == op_cls(req_op));
   assign credit_ok = (n_fly + CW'(occ)) < CW'(BUF_DEPTH);
   assign req_ready = reset && slot_ok && cls_ok && credit_ok;
   assign issue     = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sb_v <= '0;
         for (int i = 1; i <= LAT_DIV; i++) begin
            sb_op[i]  <= '0;
            sb_tag[i] <= '0;
         end
      end else begin
         sb_v <= sh_v | (issue ? tgt : '0);
         for (int i = 1; i < LAT_DIV; i++) begin
            sb_op[i]  <= sb_op[i+1];
            sb_tag[i] <= sb_tag[i+1];
         end
         for (int i = 1; i <= LAT_DIV; i++) begin
            if (issue && tgt[i]) begin
               sb_op[i]  <= req_op;
               sb_tag[i] <= req_tag;
            end
         end
      end
   end

   always_comb begin
      fpu_op_mode = mode_q;
      if (issue)        fpu_op_mode = req_op;
      else if (sb_v[1]) fpu_op_mode = sb_op[1];
   end

   assign fpu_a = issue ? req_a : a_q;
   assign fpu_b = issue ? req_b : b_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         mode_q <= fpu_op_mode;
         a_q    <= fpu_a;
         b_q    <= fpu_b;
      end
   end

   assign push = sb_v[1];
   assign pop  = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         f_tag[wptr[AW-1:0]] <= sb_tag[1];
         f_r[wptr[AW-1:0]]   <= fpu_result;
         f_r2[wptr[AW-1:0]]  <= (sb_op[1] == 2'b11) ? fpu_result2 : 32'd0;
      end
   end

   assign rsp_valid   = occ != '0;
   assign rsp_tag     = rsp_valid ? f_tag[rptr[AW-1:0]] : '0;
   assign rsp_result  = rsp_valid ? f_r[rptr[AW-1:0]] : '0;
   assign rsp_result2 = rsp_valid ? f_r2[rptr[AW-1:0]] : '0;
   assign busy        = (|sb_v) || rsp_valid;

`ifdef FPU_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_issued <= '0;
         perf_stalls <= '0;
      end else begin
         if (issue)                  perf_issued <= perf_issued + 32'd1;
         if (req_valid && !req_ready) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed bench for fpu_sched with a behavioural FPU stub.
// Build with FPU_SCHED_PERF_EN defined to also check the perf counters.
module tb_fpu_sched;

   localparam int TW = 4;
   localparam logic [31:0] ONE   = 32'h3F80_0000;
   localparam logic [31:0] TWO   = 32'h4000_0000;
   localparam logic [31:0] THREE = 32'h4040_0000;
   localparam logic [31:0] SIX   = 32'h40C0_0000;
   localparam logic [31:0] DIVR2 = 32'h00C0_0000;

   logic          clk, reset;
   logic          req_valid, req_ready;
   logic [1:0]    req_op;
   logic [31:0]   req_a, req_b;
   logic [TW-1:0] req_tag;
   logic [1:0]    fpu_op_mode;
   logic [31:0]   fpu_a, fpu_b, fpu_result, fpu_result2;
   logic          rsp_valid, rsp_ready;
   logic [TW-1:0] rsp_tag;
   logic [31:0]   rsp_result, rsp_result2;
   logic          busy;
`ifdef FPU_SCHED_PERF_EN
   logic [31:0]   perf_issued, perf_stalls;
`endif

   int errors = 0;
   int checks = 0;

   fpu_sched dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .fpu_op_mode(fpu_op_mode), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_result(fpu_result), .fpu_result2(fpu_result2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_result2(rsp_result2),
      .busy(busy)
`ifdef FPU_SCHED_PERF_EN
      , .perf_issued(perf_issued), .perf_stalls(perf_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stub FPU: each unit samples a/b every cycle, op_mode picks the output
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], e[7:0], d[51:29]};
   endfunction

   logic [1:0]  h_mode [8];
   logic [31:0] h_a [8];
   logic [31:0] h_b [8];

   always @(posedge clk) begin
      h_mode[0] <= fpu_op_mode;
      h_a[0]    <= fpu_a;
      h_b[0]    <= fpu_b;
      for (int i = 1; i < 8; i++) begin
         h_mode[i] <= h_mode[i-1];
         h_a[i]    <= h_a[i-1];
         h_b[i]    <= h_b[i-1];
      end
   end

   always_comb begin
      fpu_result  = 32'd0;
      fpu_result2 = 32'hDEAD_BEEF;
      case (fpu_op_mode)
         2'b10: fpu_result = r2f(f2r(h_a[2]) * f2r(h_b[2]));
         2'b11: begin
            fpu_result  = r2f(f2r(h_a[7]) / f2r(h_b[7]));
            fpu_result2 = h_a[7] ^ h_b[7];
         end
         default:
            if (h_mode[2] == 2'b01) fpu_result = r2f(f2r(h_a[2]) - f2r(h_b[2]));
            else                    fpu_result = r2f(f2r(h_a[2]) + f2r(h_b[2]));
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = t;
      #1;
   endtask

   task automatic nop();
      req_valid = 1'b0;
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic [TW-1:0] t,
                          input logic [31:0] r, input logic [31:0] r2);
      chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_tag"}, 32'(rsp_tag), 32'(t));
      chk({tag, "_res"}, rsp_result, r);
      chk({tag, "_res2"}, rsp_result2, r2);
   endtask

   initial begin
      reset     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = ONE;
      req_b     = TWO;
      req_tag   = '0;

      // reset state
      @(posedge clk);
      tick(); put(2'b00, ONE, TWO, 4'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("rst_rsp_res", rsp_result, 32'd0);
      chk("rst_rsp_res2", rsp_result2, 32'd0);
      chk("rst_mode", 32'(fpu_op_mode), 32'd0);
      chk("rst_fpu_a", fpu_a, 32'd0);
      chk("rst_fpu_b", fpu_b, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick(); reset = 1'b1; nop();

      // add back-to-back
      tick(); put(2'b00, ONE, TWO, 4'd1);
      chk("add_rdy0", 32'(req_ready), 32'd1);
      chk("add_fpu_a", fpu_a, ONE);
      tick(); put(2'b00, ONE, TWO, 4'd2);
      chk("add_rdy1", 32'(req_ready), 32'd1);
      tick(); put(2'b00, ONE, TWO, 4'd3);
      chk("add_rdy2", 32'(req_ready), 32'd1);
      tick(); nop();
      chk("add_nv3", 32'(rsp_valid), 32'd0);
      tick(); nop(); chk_rsp("add_r1", 4'd1, THREE, 32'd0);
      tick(); nop(); chk_rsp("add_r2", 4'd2, THREE, 32'd0);
      tick(); nop(); chk_rsp("add_r3", 4'd3, THREE, 32'd0);
      tick(); nop();
      chk("add_empty", 32'(rsp_valid), 32'd0);
      chk("add_idle", 32'(busy), 32'd0);

      // class conflict
      tick(); put(2'b11, SIX, TWO, 4'd5);
      chk("cc_rdy_div", 32'(req_ready), 32'd1);
      repeat (7) begin tick(); nop(); end
      tick(); put(2'b00, ONE, TWO, 4'd6);
      chk("cc_stall8", 32'(req_ready), 32'd0);
      chk("cc_mode8", 32'(fpu_op_mode), 32'd3);
      tick(); put(2'b00, ONE, TWO, 4'd6);
      chk("cc_issue9", 32'(req_ready), 32'd1);
      chk_rsp("cc_div", 4'd5, THREE, DIVR2);
      tick(); nop();
      chk("cc_nv10", 32'(rsp_valid), 32'd0);
      repeat (2) begin tick(); nop(); end
      tick(); nop(); chk_rsp("cc_add", 4'd6, THREE, 32'd0);

      // reorder: mul overtakes div
      tick(); put(2'b11, SIX, TWO, 4'd1);
      chk("ro_rdy_div", 32'(req_ready), 32'd1);
      tick(); put(2'b10, THREE, TWO, 4'd2);
      chk("ro_rdy_mul", 32'(req_ready), 32'd1);
      repeat (3) begin tick(); nop(); end
      tick(); nop(); chk_rsp("ro_mul", 4'd2, SIX, 32'd0);
      tick(); nop();
      chk("ro_nv6", 32'(rsp_valid), 32'd0);
      chk("ro_busy6", 32'(busy), 32'd1);
      repeat (2) begin tick(); nop(); end
      tick(); nop(); chk_rsp("ro_div", 4'd1, THREE, DIVR2);
      tick(); nop();
      chk("ro_idle", 32'(busy), 32'd0);

      // backpressure, after a reset so perf counters start at 0
      tick(); reset = 1'b0; nop();
      tick(); reset = 1'b1; nop();
`ifdef FPU_SCHED_PERF_EN
      chk("bp_perf_clr", perf_issued, 32'd0);
`endif
      rsp_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick(); put(2'b00, ONE, TWO, TW'(i));
         chk("bp_rdy", 32'(req_ready), 32'd1);
      end
      repeat (4) begin
         tick(); put(2'b00, ONE, TWO, 4'd5);
         chk("bp_stall", 32'(req_ready), 32'd0);
      end
      tick(); rsp_ready = 1'b1; put(2'b00, ONE, TWO, 4'd5);
      chk("bp_stall8", 32'(req_ready), 32'd0);
      chk_rsp("bp_r1", 4'd1, THREE, 32'd0);
      tick(); put(2'b00, ONE, TWO, 4'd5);
      chk("bp_resume9", 32'(req_ready), 32'd1);
      chk_rsp("bp_r2", 4'd2, THREE, 32'd0);
`ifdef FPU_SCHED_PERF_EN
      chk("bp_perf_issued", perf_issued, 32'd4);
      chk("bp_perf_stalls", perf_stalls, 32'd5);
`endif
      tick(); put(2'b00, ONE, TWO, 4'd6);
      chk("bp_rdy10", 32'(req_ready), 32'd1);
      chk_rsp("bp_r3", 4'd3, THREE, 32'd0);
      tick(); nop(); chk_rsp("bp_r4", 4'd4, THREE, 32'd0);
      tick(); nop();
      chk("bp_nv12", 32'(rsp_valid), 32'd0);
      tick(); nop(); chk_rsp("bp_r5", 4'd5, THREE, 32'd0);
      tick(); nop(); chk_rsp("bp_r6", 4'd6, THREE, 32'd0);
      tick(); nop();
      chk("bp_idle", 32'(busy), 32'd0);

      // reset mid-flight
      tick(); put(2'b11, SIX, TWO, 4'd7);
      chk("mr_rdy", 32'(req_ready), 32'd1);
      repeat (2) begin tick(); nop(); end
      tick(); reset = 1'b0; nop();
      chk("mr_rdy_rst", 32'(req_ready), 32'd0);
      chk("mr_busy3", 32'(busy), 32'd1);
      tick(); reset = 1'b1; nop();
      chk("mr_busy4", 32'(busy), 32'd0);
      chk("mr_nv4", 32'(rsp_valid), 32'd0);
      for (int c = 5; c <= 12; c++) begin
         tick(); nop();
         chk("mr_nv", 32'(rsp_valid), 32'd0);
      end
      chk("mr_busy_end", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
